// File: rtl/lowampa_trigger_generator.sv
// Low-amplitude trigger sequencer: run-state/mask/holdoff gating, timestamped FWFT FIFO, AXI4-Stream out.
// Optional trigger/drop counters are enabled by defining LOWAMPA_TRIG_COUNT_EN.
module lowampa_trigger_generator #(
  parameter int NBEAMS        = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int AGC_RESET_LEN = 4
) (
  input  logic              ifclk,
  input  logic              ifclk_rst_i,
  input  logic [NBEAMS-1:0] trig_i,
  input  logic [NBEAMS-1:0] beam_mask_i,
  input  logic [15:0]       holdoff_i,
  input  logic              runrst_i,
  input  logic              runstop_i,
  output logic              running_o,
  output logic              agc_reset_o,
  output logic [31:0]       m_trig_tdata,
  output logic              m_trig_tvalid,
  input  logic              m_trig_tready
`ifdef LOWAMPA_TRIG_COUNT_EN
  ,
  output logic [31:0]       trig_count_o,
  output logic [15:0]       drop_count_o
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]  AGC_LEN  = 8'(AGC_RESET_LEN);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [15:0] ts_q, ts_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  agc_cnt_q, agc_cnt_d;
  logic        agc_q, running_q, valid_q;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q, cnt_d;

  logic [NBEAMS-1:0] masked_s;
  logic [15:0]       masked16_s;
  logic [31:0]       word_s;
  logic full_s, start_s, hit_s, push_s, drop_s, pop_s;

  // Trigger qualification and FIFO handshake terms
  always_comb begin
    masked_s   = trig_i & beam_mask_i;
    masked16_s = 16'd0;
    masked16_s[NBEAMS-1:0] = masked_s;
    word_s  = {ts_q, masked16_s};
    full_s  = (cnt_q == CNT_FULL);
    start_s = runrst_i & ~runstop_i;
    // run strobes take priority over a coincident trigger
    hit_s   = (state_q == ST_RUN) & (|masked_s) & ~runrst_i & ~runstop_i;
    push_s  = hit_s & ~full_s;
    drop_s  = hit_s & full_s;
    pop_s   = valid_q & m_trig_tready;
  end

  // Next-state logic for run FSM, timestamp, holdoff, occupancy and AGC pulse
  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_RUN;
          ts_d    = 16'd0;
          hold_d  = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_HOLD: begin
        ts_d = ts_q + 16'd1;
        if (runstop_i) begin
          state_d = ST_IDLE;
        end else if (runrst_i) begin
          state_d = ST_RUN;
          ts_d    = 16'd0;
          hold_d  = 16'd0;
        end else if (state_q == ST_RUN) begin
          if (push_s) begin
            hold_d  = holdoff_i;
            state_d = (holdoff_i != 16'd0) ? ST_HOLD : ST_RUN;
          end else begin
            state_d = ST_RUN;
          end
        end else if (hold_q <= 16'd1) begin
          state_d = ST_RUN;
          hold_d  = 16'd0;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 16'd0;
      end
    endcase

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase

    if (start_s) begin
      agc_cnt_d = AGC_LEN;
    end else if (agc_cnt_q != 8'd0) begin
      agc_cnt_d = agc_cnt_q - 8'd1;
    end else begin
      agc_cnt_d = 8'd0;
    end
  end

  // All sequencer, FIFO and output registers
  always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
    if (ifclk_rst_i) begin
      state_q   <= ST_IDLE;
      ts_q      <= 16'd0;
      hold_q    <= 16'd0;
      agc_cnt_q <= 8'd0;
      agc_q     <= 1'b0;
      running_q <= 1'b0;
      valid_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      hold_q    <= hold_d;
      agc_cnt_q <= agc_cnt_d;
      agc_q     <= (agc_cnt_d != 8'd0);
      running_q <= (state_d != ST_IDLE);
      valid_q   <= (cnt_d != '0);
      cnt_q     <= cnt_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= word_s;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign running_o     = running_q;
  assign agc_reset_o   = agc_q;
  assign m_trig_tvalid = valid_q;
  assign m_trig_tdata  = mem_q[rd_ptr_q];

`ifdef LOWAMPA_TRIG_COUNT_EN
  logic [31:0] trig_cnt_q;
  logic [15:0] drop_cnt_q;

  // Saturating accepted/dropped trigger counters, cleared at run start
  always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
    if (ifclk_rst_i) begin
      trig_cnt_q <= 32'd0;
      drop_cnt_q <= 16'd0;
    end else if (start_s) begin
      trig_cnt_q <= 32'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      if (push_s && (trig_cnt_q != 32'hFFFF_FFFF)) trig_cnt_q <= trig_cnt_q + 32'd1;
      if (drop_s && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign trig_count_o = trig_cnt_q;
  assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_lowampa_trigger_generator.sv
// Scoreboard bench for lowampa_trigger_generator: directed stimulus pushes expected words, a monitor pops and compares.
module tb_lowampa_trigger_generator;

  logic        ifclk = 1'b0;
  logic        ifclk_rst_i = 1'b1;
  logic [1:0]  trig_i = 2'b00;
  logic [1:0]  beam_mask_i = 2'b11;
  logic [15:0] holdoff_i = 16'd0;
  logic        runrst_i = 1'b0;
  logic        runstop_i = 1'b0;
  logic        running_o, agc_reset_o;
  logic [31:0] m_trig_tdata;
  logic        m_trig_tvalid;
  logic        m_trig_tready = 1'b1;
`ifdef LOWAMPA_TRIG_COUNT_EN
  logic [31:0] trig_count_o;
  logic [15:0] drop_count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];

  lowampa_trigger_generator #(.NBEAMS(2), .FIFO_DEPTH(4), .AGC_RESET_LEN(4)) dut (
    .ifclk        (ifclk),
    .ifclk_rst_i  (ifclk_rst_i),
    .trig_i       (trig_i),
    .beam_mask_i  (beam_mask_i),
    .holdoff_i    (holdoff_i),
    .runrst_i     (runrst_i),
    .runstop_i    (runstop_i),
    .running_o    (running_o),
    .agc_reset_o  (agc_reset_o),
    .m_trig_tdata (m_trig_tdata),
    .m_trig_tvalid(m_trig_tvalid),
    .m_trig_tready(m_trig_tready)
`ifdef LOWAMPA_TRIG_COUNT_EN
    ,
    .trig_count_o (trig_count_o),
    .drop_count_o (drop_count_o)
`endif
  );

  always #5 ifclk = ~ifclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ifclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // After return the current cycle is the first RUN cycle, timestamp 0
  task automatic pulse_runrst();
    runrst_i = 1'b1;
    tick();
    runrst_i = 1'b0;
  endtask

  task automatic monitor();
    logic [31:0] exp;
    forever begin
      @(negedge ifclk);
      if (!ifclk_rst_i && m_trig_tvalid && m_trig_tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%08h expected no word", m_trig_tdata);
        end else begin
          exp = sb.pop_front();
          check("trig_word", m_trig_tdata, exp);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    ticks(3);
    check("rst_tvalid", {31'd0, m_trig_tvalid}, 32'd0);
    check("rst_running", {31'd0, running_o}, 32'd0);
    check("rst_agc", {31'd0, agc_reset_o}, 32'd0);
    check("rst_tdata", m_trig_tdata, 32'd0);
    ifclk_rst_i = 1'b0;

    // Triggers in IDLE are ignored
    trig_i = 2'b01; tick(); trig_i = 2'b00;
    ticks(4);
    check("idle_no_word", {31'd0, m_trig_tvalid}, 32'd0);

    // Run start, AGC pulse, first word with one-cycle latency
    pulse_runrst();
    check("running_rise", {31'd0, running_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("agc_high", {31'd0, agc_reset_o}, 32'd1);
      tick();
    end
    check("agc_low", {31'd0, agc_reset_o}, 32'd0);
    ticks(5);
    trig_i = 2'b01;
    sb.push_back(32'h0009_0001);
    tick();
    trig_i = 2'b00;
    check("latency_tvalid", {31'd0, m_trig_tvalid}, 32'd1);
    tick();
    check("drained_tvalid", {31'd0, m_trig_tvalid}, 32'd0);

    // Holdoff of 5 with trigger held: accepts at offsets 0, 6, 12
    holdoff_i = 16'd5;
    pulse_runrst();
    sb.push_back(32'h0000_0003);
    sb.push_back(32'h0006_0003);
    sb.push_back(32'h000C_0003);
    for (int i = 0; i < 13; i++) begin
      trig_i = 2'b11;
      tick();
    end
    trig_i = 2'b00;
    check("hold_running", {31'd0, running_o}, 32'd1);
    ticks(3);
    check("hold_sb_empty", sb.size(), 32'd0);
    holdoff_i = 16'd0;
    ticks(4);

    // Backpressure: 6 pulses into depth-4 FIFO, 2 dropped
    m_trig_tready = 1'b0;
    pulse_runrst();
    for (int k = 0; k < 6; k++) begin
      trig_i = 2'b01;
      if (k < 4) sb.push_back({16'(2 * k), 16'h0001});
      tick();
      trig_i = 2'b00;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_tvalid", {31'd0, m_trig_tvalid}, 32'd1);
      check("bp_tdata_stable", m_trig_tdata, 32'h0000_0001);
      tick();
    end
`ifdef LOWAMPA_TRIG_COUNT_EN
    check("trig_count", trig_count_o, 32'd4);
    check("drop_count", {16'd0, drop_count_o}, 32'd2);
`endif
    m_trig_tready = 1'b1;
    ticks(6);
    check("bp_sb_empty", sb.size(), 32'd0);
    check("bp_tvalid_after", {31'd0, m_trig_tvalid}, 32'd0);

    // Timestamp wrap
    pulse_runrst();
    ticks(65539);
    trig_i = 2'b01;
    sb.push_back(32'h0003_0001);
    tick();
    trig_i = 2'b00;
    ticks(3);
    check("wrap_sb_empty", sb.size(), 32'd0);

    // runstop and runrst together in HOLD: stop wins, pending word still drains
    m_trig_tready = 1'b0;
    holdoff_i = 16'd10;
    pulse_runrst();
    trig_i = 2'b01;
    sb.push_back(32'h0000_0001);
    tick();
    trig_i = 2'b00;
    runstop_i = 1'b1;
    runrst_i  = 1'b1;
    tick();
    runstop_i = 1'b0;
    runrst_i  = 1'b0;
    check("stop_running", {31'd0, running_o}, 32'd0);
    trig_i = 2'b11;
    ticks(5);
    trig_i = 2'b00;
    check("stop_pending_valid", {31'd0, m_trig_tvalid}, 32'd1);
    m_trig_tready = 1'b1;
    ticks(3);
    check("stop_sb_empty", sb.size(), 32'd0);
    check("stop_tvalid_after", {31'd0, m_trig_tvalid}, 32'd0);
    holdoff_i = 16'd0;

    // Beam mask gating
    beam_mask_i = 2'b10;
    pulse_runrst();
    trig_i = 2'b01;
    tick();
    trig_i = 2'b00;
    tick();
    trig_i = 2'b11;
    sb.push_back(32'h0002_0002);
    tick();
    trig_i = 2'b00;
    ticks(3);
    check("mask_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
